// File: rtl/ulpi_link.sv
// ULPI link-layer engine: programs the PHY into non-driving sniff mode after
// reset, decodes PHY-driven cycles into an RX byte stream plus RX CMD status,
// and performs single register writes on behalf of the sniffer core.
module ulpi_link #(
    parameter int unsigned INIT_DELAY     = 16,
    parameter logic [5:0]  FUNC_CTRL_ADDR = 6'h04,
    parameter logic [7:0]  FUNC_CTRL_INIT = 8'h48
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] ulpi_data_i,
    output logic [7:0] ulpi_data_o,
    input  logic       ulpi_dir_i,
    input  logic       ulpi_nxt_i,
    output logic       ulpi_stp_o,
    input  logic       reg_wr_i,
    input  logic [5:0] reg_addr_i,
    input  logic [7:0] reg_data_i,
    output logic       reg_busy_o,
    output logic       reg_done_o,
    output logic       ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_active_o,
    output logic       rx_error_o,
    output logic [1:0] linestate_o
);

    localparam int unsigned CW = $clog2(INIT_DELAY) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(INIT_DELAY - 1);

    typedef enum logic [2:0] {INIT_WAIT, IDLE, CMD, DATA, STP} state_t;

    state_t        state, state_n;
    logic          dir_q;
    logic [CW-1:0] cnt, cnt_n;
    logic          pend, pend_n;
    logic [5:0]    pend_addr, pend_addr_n;
    logic [7:0]    pend_data, pend_data_n;
    logic [7:0]    data_n;
    logic          stp_n, busy_n, done_n, ready_n;
    logic          start, accept, rx_byte, rx_cmd;
    logic          act_n, err_n;

    assign start   = pend && !ulpi_dir_i && !dir_q;
    assign accept  = ready_o && !reg_busy_o && reg_wr_i;
    assign rx_byte = ulpi_dir_i && dir_q && ulpi_nxt_i;
    assign rx_cmd  = ulpi_dir_i && dir_q && !ulpi_nxt_i;

    // TX state register and registered bus/handshake outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= INIT_WAIT;
            cnt         <= '0;
            pend        <= 1'b0;
            pend_addr   <= '0;
            pend_data   <= '0;
            ulpi_data_o <= '0;
            ulpi_stp_o  <= 1'b0;
            reg_busy_o  <= 1'b0;
            reg_done_o  <= 1'b0;
            ready_o     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            pend        <= pend_n;
            pend_addr   <= pend_addr_n;
            pend_data   <= pend_data_n;
            ulpi_data_o <= data_n;
            ulpi_stp_o  <= stp_n;
            reg_busy_o  <= busy_n;
            reg_done_o  <= done_n;
            ready_o     <= ready_n;
        end
    end

    // TX next-state: a PHY turnaround in CMD/DATA aborts back to IDLE
    always_comb begin
        state_n = state;
        case (state)
            INIT_WAIT: if (cnt == CNT_LAST) state_n = IDLE;
            IDLE:      if (start) state_n = CMD;
            CMD:       if (ulpi_dir_i) state_n = IDLE;
                       else if (ulpi_nxt_i) state_n = DATA;
            DATA:      if (ulpi_dir_i) state_n = IDLE;
                       else if (ulpi_nxt_i) state_n = STP;
            STP:       state_n = IDLE;
            default:   state_n = INIT_WAIT;
        endcase
    end

    // TX outputs, pending-write bookkeeping and request acceptance
    always_comb begin
        cnt_n       = cnt;
        pend_n      = pend;
        pend_addr_n = pend_addr;
        pend_data_n = pend_data;
        data_n      = ulpi_data_o;
        stp_n       = 1'b0;
        busy_n      = reg_busy_o;
        done_n      = 1'b0;
        ready_n     = ready_o;
        case (state)
            INIT_WAIT: begin
                data_n = '0;
                if (cnt == CNT_LAST) begin
                    pend_n      = 1'b1;
                    pend_addr_n = FUNC_CTRL_ADDR;
                    pend_data_n = FUNC_CTRL_INIT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            IDLE: begin
                data_n = start ? {2'b10, pend_addr} : 8'h00;
            end
            CMD: begin
                if (ulpi_dir_i) data_n = '0;
                else if (ulpi_nxt_i) data_n = pend_data;
            end
            DATA: begin
                if (ulpi_dir_i) data_n = '0;
                else if (ulpi_nxt_i) begin
                    data_n = '0;
                    stp_n  = 1'b1;
                end
            end
            STP: begin
                data_n = '0;
                pend_n = 1'b0;
                // only user writes ever raise busy, so it tells the two kinds apart
                if (reg_busy_o) begin
                    done_n = 1'b1;
                    busy_n = 1'b0;
                end else begin
                    ready_n = 1'b1;
                end
            end
            default: data_n = '0;
        endcase
        if (accept) begin
            pend_n      = 1'b1;
            pend_addr_n = reg_addr_i;
            pend_data_n = reg_data_i;
            busy_n      = 1'b1;
        end
    end

    // RX status next values: packet activity and sticky per-packet error
    always_comb begin
        act_n = rx_active_o;
        err_n = rx_error_o;
        if (ulpi_dir_i && !dir_q && ulpi_nxt_i) act_n = 1'b1;
        if (!ulpi_dir_i && dir_q) act_n = 1'b0;
        if (rx_cmd) act_n = ulpi_data_i[4];
        if (act_n && !rx_active_o) err_n = 1'b0;
        if (rx_cmd && ulpi_data_i[5:4] == 2'b11) err_n = 1'b1;
    end

    // RX registers: direction history, data bytes and RX CMD linestate
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dir_q       <= 1'b0;
            rx_data_o   <= '0;
            rx_valid_o  <= 1'b0;
            rx_active_o <= 1'b0;
            rx_error_o  <= 1'b0;
            linestate_o <= '0;
        end else begin
            dir_q       <= ulpi_dir_i;
            rx_valid_o  <= rx_byte;
            rx_active_o <= act_n;
            rx_error_o  <= err_n;
            if (rx_byte) rx_data_o <= ulpi_data_i;
            if (rx_cmd) linestate_o <= ulpi_data_i[1:0];
        end
    end

endmodule

// File: tb/tb_ulpi_link.sv
// Self-checking bench for ulpi_link: directed/randomized PHY behaviour with a
// rule-level RX status model and sequence checks on register writes.
module tb_ulpi_link;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ulpi_data_i;
    logic [7:0] ulpi_data_o;
    logic       ulpi_dir_i;
    logic       ulpi_nxt_i;
    logic       ulpi_stp_o;
    logic       reg_wr_i;
    logic [5:0] reg_addr_i;
    logic [7:0] reg_data_i;
    logic       reg_busy_o;
    logic       reg_done_o;
    logic       ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_active_o;
    logic       rx_error_o;
    logic [1:0] linestate_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // RX reference state
    logic       m_dprev, m_act, m_err, m_valid;
    logic [1:0] m_ls;
    logic [7:0] m_data;

    ulpi_link dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ulpi_data_i (ulpi_data_i),
        .ulpi_data_o (ulpi_data_o),
        .ulpi_dir_i  (ulpi_dir_i),
        .ulpi_nxt_i  (ulpi_nxt_i),
        .ulpi_stp_o  (ulpi_stp_o),
        .reg_wr_i    (reg_wr_i),
        .reg_addr_i  (reg_addr_i),
        .reg_data_i  (reg_data_i),
        .reg_busy_o  (reg_busy_o),
        .reg_done_o  (reg_done_o),
        .ready_o     (ready_o),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_active_o (rx_active_o),
        .rx_error_o  (rx_error_o),
        .linestate_o (linestate_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dprev = 1'b0; m_act = 1'b0; m_err = 1'b0; m_valid = 1'b0;
        m_ls = 2'b00; m_data = 8'h00;
    endtask

    // what the PHY cycle about to be clocked means for RX status
    task automatic model_step();
        logic turn;
        turn = (ulpi_dir_i != m_dprev);
        m_valid = 1'b0;
        if (ulpi_dir_i && !turn) begin
            if (ulpi_nxt_i) begin
                m_valid = 1'b1;
                m_data  = ulpi_data_i;
            end else begin
                m_ls = ulpi_data_i[1:0];
                case (ulpi_data_i[5:4])
                    2'b01: begin if (!m_act) m_err = 1'b0; m_act = 1'b1; end
                    2'b11: begin m_act = 1'b1; m_err = 1'b1; end
                    default: m_act = 1'b0;
                endcase
            end
        end
        if (ulpi_dir_i && !m_dprev && ulpi_nxt_i) begin
            if (!m_act) m_err = 1'b0;
            m_act = 1'b1;
        end
        if (!ulpi_dir_i && m_dprev) m_act = 1'b0;
        m_dprev = ulpi_dir_i;
    endtask

    task automatic tick();
        if (!rst) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_check();
        chk("rx_valid", rx_valid_o, m_valid);
        if (m_valid) chk("rx_data", rx_data_o, m_data);
        chk("rx_active", rx_active_o, m_act);
        chk("rx_error", rx_error_o, m_err);
        chk("linestate", linestate_o, m_ls);
    endtask

    task automatic rx_drive(input logic d, input logic n, input logic [7:0] b);
        ulpi_dir_i = d; ulpi_nxt_i = n; ulpi_data_i = b;
        tick();
        rx_check();
        chk("tx_quiet", ulpi_data_o, 8'h00);
    endtask

    task automatic check_zero(input string tag);
        chk(tag, {ulpi_data_o, ulpi_stp_o, reg_busy_o, reg_done_o, ready_o,
                  rx_data_o, rx_valid_o, rx_active_o, rx_error_o, linestate_o}, 32'd0);
    endtask

    // entered with the command byte just presented on the bus
    task automatic tx_write(input logic [5:0] a, input logic [7:0] d, input logic user,
                            input int unsigned h1, input int unsigned h2);
        chk("cmd_byte", ulpi_data_o, {2'b10, a});
        repeat (h1) begin
            tick();
            chk("cmd_hold", ulpi_data_o, {2'b10, a});
            chk("cmd_stp", ulpi_stp_o, 1'b0);
        end
        ulpi_nxt_i = 1'b1; tick(); ulpi_nxt_i = 1'b0;
        chk("data_byte", ulpi_data_o, d);
        repeat (h2) begin
            tick();
            chk("data_hold", ulpi_data_o, d);
            chk("data_stp", ulpi_stp_o, 1'b0);
        end
        ulpi_nxt_i = 1'b1; tick(); ulpi_nxt_i = 1'b0;
        chk("stp_data", ulpi_data_o, 8'h00);
        chk("stp_high", ulpi_stp_o, 1'b1);
        chk("stp_done_early", reg_done_o, 1'b0);
        tick();
        chk("stp_low", ulpi_stp_o, 1'b0);
        chk("done_pulse", reg_done_o, user);
        chk("busy_fall", reg_busy_o, 1'b0);
        chk("ready", ready_o, 1'b1);
        tick();
        chk("done_once", reg_done_o, 1'b0);
        chk("idle_data", ulpi_data_o, 8'h00);
    endtask

    task automatic user_write(input logic [5:0] a, input logic [7:0] d,
                              input int unsigned h1, input int unsigned h2);
        reg_wr_i = 1'b1; reg_addr_i = a; reg_data_i = d;
        tick();
        chk("busy_rise", reg_busy_o, 1'b1);
        chk("accept_data", ulpi_data_o, 8'h00);
        // a second request while busy must be ignored
        reg_addr_i = a ^ 6'h3F; reg_data_i = ~d;
        tick();
        reg_wr_i = 1'b0;
        chk("busy_hold", reg_busy_o, 1'b1);
        tx_write(a, d, 1'b1, h1, h2);
        tick();
        chk("no_extra_write", ulpi_data_o, 8'h00);
    endtask

    task automatic init_until_cmd();
        repeat (16) tick();
        chk("init_wait_data", ulpi_data_o, 8'h00);
        chk("init_wait_ready", ready_o, 1'b0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        ulpi_data_i = 8'h00; ulpi_dir_i = 1'b0; ulpi_nxt_i = 1'b0;
        reg_wr_i = 1'b0; reg_addr_i = 6'h00; reg_data_i = 8'h00;
        model_reset();
        #1;
        check_zero("reset_state");
        tick(); tick();
        rst = 1'b0;

        // init sequence; a request before ready must be ignored
        reg_wr_i = 1'b1; reg_addr_i = 6'h3F; reg_data_i = 8'hFF;
        repeat (10) tick();
        reg_wr_i = 1'b0;
        repeat (6) tick();
        chk("init_wait_data", ulpi_data_o, 8'h00);
        chk("early_req_busy", reg_busy_o, 1'b0);
        tick();
        tx_write(6'h04, 8'h48, 1'b0, 1, 1);

        // user writes: directed then random
        user_write(6'h0A, 8'h00, 1, 1);
        repeat (4) user_write(6'($urandom), 8'($urandom),
                              $urandom_range(1, 3), $urandom_range(1, 3));

        // RX: directed packet
        rx_drive(1'b1, 1'b1, 8'hFF);
        chk("pkt_start_active", rx_active_o, 1'b1);
        rx_drive(1'b1, 1'b1, 8'hA5);
        chk("byte_a5", rx_data_o, 8'hA5);
        rx_drive(1'b1, 1'b1, 8'h5A);
        chk("byte_5a", rx_data_o, 8'h5A);
        rx_drive(1'b1, 1'b0, 8'h00);
        chk("rxcmd_end_active", rx_active_o, 1'b0);
        rx_drive(1'b0, 1'b0, 8'h00);

        // RX: error event, then cleared by the next packet start
        rx_drive(1'b1, 1'b1, 8'h00);
        rx_drive(1'b1, 1'b0, 8'h31);
        chk("err_set", rx_error_o, 1'b1);
        chk("err_ls", linestate_o, 2'b01);
        rx_drive(1'b0, 1'b0, 8'h00);
        rx_drive(1'b1, 1'b1, 8'h00);
        chk("err_clear", rx_error_o, 1'b0);
        rx_drive(1'b1, 1'b0, 8'h00);
        rx_drive(1'b0, 1'b0, 8'h00);

        // RX: random packets with interleaved RX CMDs
        repeat (8) begin
            rx_drive(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
            repeat ($urandom_range(1, 8)) begin
                if ($urandom_range(0, 3) == 0) rx_drive(1'b1, 1'b0, 8'($urandom));
                else rx_drive(1'b1, 1'b1, 8'($urandom));
            end
            rx_drive(1'b1, 1'b0, 8'($urandom));
            rx_drive(1'b0, 1'b0, 8'($urandom));
            rx_drive(1'b0, 1'b0, 8'h00);
        end

        // leave RX status non-zero, then reset in the middle of a user write
        rx_drive(1'b1, 1'b1, 8'h00);
        rx_drive(1'b1, 1'b0, 8'h3B);
        rx_drive(1'b0, 1'b0, 8'h00);
        reg_wr_i = 1'b1; reg_addr_i = 6'h15; reg_data_i = 8'hC3;
        tick();
        reg_wr_i = 1'b0;
        tick();
        chk("pre_reset_cmd", ulpi_data_o, 8'h95);
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        model_reset();
        tick();
        rst = 1'b0;

        // restarted init, aborted by PHY turnaround in DATA, then retried
        init_until_cmd();
        chk("restart_cmd", ulpi_data_o, 8'h84);
        tick();
        ulpi_nxt_i = 1'b1; tick(); ulpi_nxt_i = 1'b0;
        chk("abort_data_byte", ulpi_data_o, 8'h48);
        ulpi_dir_i = 1'b1; ulpi_data_i = 8'($urandom);
        tick();
        chk("abort_data", ulpi_data_o, 8'h00);
        chk("abort_stp", ulpi_stp_o, 1'b0);
        repeat (3) begin
            ulpi_nxt_i = 1'($urandom_range(0, 1)); ulpi_data_i = 8'($urandom);
            tick();
        end
        ulpi_nxt_i = 1'b0;
        chk("abort_ready", ready_o, 1'b0);
        ulpi_dir_i = 1'b0;
        tick();
        chk("retry_wait", ulpi_data_o, 8'h00);
        tick();
        tx_write(6'h04, 8'h48, 1'b0, 2, 2);

        // user write aborted in CMD, retried automatically
        reg_wr_i = 1'b1; reg_addr_i = 6'h2C; reg_data_i = 8'h7E;
        tick();
        reg_wr_i = 1'b0;
        tick();
        chk("abort_cmd_byte", ulpi_data_o, 8'hAC);
        ulpi_dir_i = 1'b1; ulpi_nxt_i = 1'b1;
        tick();
        ulpi_nxt_i = 1'b0;
        chk("abort_cmd_data", ulpi_data_o, 8'h00);
        chk("abort_cmd_busy", reg_busy_o, 1'b1);
        ulpi_dir_i = 1'b0;
        tick();
        chk("abort_cmd_wait", ulpi_data_o, 8'h00);
        tick();
        tx_write(6'h2C, 8'h7E, 1'b1, 1, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
